pulse_playback: RTL and testbench



---
 rtl/pulse_pkg.sv | 29 ++
 rtl/pulse_skid_fifo.sv | 66 ++++++
 rtl/pulse_playback.sv | 179 +++++++++++++++++
 tb/tb_pulse_playback.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared constants, FSM state type and stream payload types for the pulse playback sequencer.
package pulse_pkg;

  localparam int unsigned PULSE_DEPTH     = 8000;
  localparam int unsigned PULSE_AW        = 13;
  localparam int unsigned PULSE_DW        = 32;
  localparam int unsigned PULSE_ADDR_STEP = 1;
  localparam int unsigned PULSE_CNT_W     = 13;

  typedef enum logic [1:0] {PB_IDLE, PB_RUN, PB_DRAIN} pb_state_t;

  typedef logic [PULSE_DW-1:0] pulse_sample_t;

  typedef struct packed {
    logic          last;
    pulse_sample_t data;
  } pulse_entry_t;

  // Advance a word index by the address step, wrapping modulo the memory depth.
  function automatic logic [PULSE_AW-1:0] pulse_wrap_inc(input logic [PULSE_AW-1:0] idx);
    logic [PULSE_AW:0] sum;
    sum = {1'b0, idx} + (PULSE_AW+1)'(PULSE_ADDR_STEP);
    if (sum >= (PULSE_AW+1)'(PULSE_DEPTH)) begin
      sum = sum - (PULSE_AW+1)'(PULSE_DEPTH);
    end
    return sum[PULSE_AW-1:0];
  endfunction

endpackage

// File: rtl/pulse_skid_fifo.sv
// Two-entry data+last FIFO that absorbs the BRAM read latency; the head entry drives the stream.
module pulse_skid_fifo
  import pulse_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         wr_en_i,
  input  pulse_entry_t wr_i,
  input  logic         rd_en_i,
  output pulse_entry_t head_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);

  pulse_entry_t e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  // Flush beats any same-cycle write so a cancelled read never lands.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    pop   = rd_en_i && (cnt_q != 2'd0);
    if (flush_i) begin
      cnt_d = 2'd0;
    end else if (wr_en_i && pop) begin
      if (cnt_q == 2'd1) begin
        e0_d = wr_i;
      end else begin
        e0_d = e1_q;
        e1_d = wr_i;
      end
    end else if (wr_en_i) begin
      if (cnt_q == 2'd0) begin
        e0_d = wr_i;
      end else begin
        e1_d = wr_i;
      end
      if (cnt_q != 2'd2) begin
        cnt_d = cnt_q + 2'd1;
      end
    end else if (pop) begin
      e0_d  = e1_q;
      cnt_d = cnt_q - 2'd1;
    end
  end

  assign head_o  = e0_q;
  assign valid_o = (cnt_q != 2'd0);
  assign count_o = cnt_q;

endmodule

// File: rtl/pulse_playback.sv
// Read-side sequencer: plays a window of the pulse-sample BRAM out as a valid/ready/last stream.
// Optional PULSE_PLAYBACK_LOOP_EN adds repeat_i for continuous looped playback ended by abort.
module pulse_playback
  import pulse_pkg::*;
(
`ifdef PULSE_PLAYBACK_LOOP_EN
  input  logic                   repeat_i,
`endif
  input  logic                   clka,
  input  logic                   rsta,
  input  logic                   start,
  input  logic                   abort,
  input  logic [PULSE_AW-1:0]    start_addr,
  input  logic [PULSE_CNT_W-1:0] num_samples,
  output logic                   busy,
  output logic                   done,
  output logic                   ena,
  output logic                   wea,
  output logic [31:0]            addra,
  output logic [31:0]            dina,
  input  logic [31:0]            douta,
  output pulse_sample_t          m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast
);

  pb_state_t              state_q, state_d;
  logic [PULSE_AW-1:0]    addr_q, addr_d;
  logic [PULSE_CNT_W-1:0] rem_q, rem_d;
  logic                   busy_q, busy_d, done_q, done_d;
  logic                   rdv_q, rdv_d, rdv_last_q, rdv_last_d;
  logic                   fifo_flush, acc, ena_c;
  logic [1:0]             fifo_count;
  logic [2:0]             used;
  logic [PULSE_AW-1:0]    start_idx;
  logic [PULSE_CNT_W-1:0] n_sat;
  pulse_entry_t           head;
`ifdef PULSE_PLAYBACK_LOOP_EN
  logic [PULSE_AW-1:0]    loop_addr_q, loop_addr_d;
  logic [PULSE_CNT_W-1:0] loop_cnt_q, loop_cnt_d;
  logic                   loop_rep_q, loop_rep_d;
`endif

  assign start_idx = (start_addr >= PULSE_AW'(PULSE_DEPTH)) ?
                     start_addr - PULSE_AW'(PULSE_DEPTH) : start_addr;
  assign n_sat     = (num_samples > PULSE_CNT_W'(PULSE_DEPTH)) ?
                     PULSE_CNT_W'(PULSE_DEPTH) : num_samples;

  // Read credit counts the same-cycle accept so a free-flowing sink sees one sample per cycle.
  assign acc   = m_tvalid & m_tready;
  assign used  = 3'(fifo_count) + 3'(rdv_q) - 3'(acc);
  assign ena_c = (state_q == PB_RUN) && !abort && (used < 3'd2);

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state_q    <= PB_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rdv_q      <= 1'b0;
      rdv_last_q <= 1'b0;
`ifdef PULSE_PLAYBACK_LOOP_EN
      loop_addr_q <= '0;
      loop_cnt_q  <= '0;
      loop_rep_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rdv_q      <= rdv_d;
      rdv_last_q <= rdv_last_d;
`ifdef PULSE_PLAYBACK_LOOP_EN
      loop_addr_q <= loop_addr_d;
      loop_cnt_q  <= loop_cnt_d;
      loop_rep_q  <= loop_rep_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rdv_d      = ena_c;
    rdv_last_d = ena_c && (rem_q == PULSE_CNT_W'(1));
    fifo_flush = 1'b0;
`ifdef PULSE_PLAYBACK_LOOP_EN
    loop_addr_d = loop_addr_q;
    loop_cnt_d  = loop_cnt_q;
    loop_rep_d  = loop_rep_q;
`endif
    case (state_q)
      PB_IDLE: begin
        if (start) begin
          if (n_sat == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = PB_RUN;
            busy_d  = 1'b1;
            addr_d  = start_idx;
            rem_d   = n_sat;
`ifdef PULSE_PLAYBACK_LOOP_EN
            loop_addr_d = start_idx;
            loop_cnt_d  = n_sat;
            loop_rep_d  = repeat_i;
`endif
          end
        end
      end
      PB_RUN: begin
        if (abort) begin
          state_d    = PB_IDLE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          fifo_flush = 1'b1;
          rdv_d      = 1'b0;
        end else if (ena_c) begin
          addr_d = pulse_wrap_inc(addr_q);
          rem_d  = rem_q - PULSE_CNT_W'(1);
          if (rem_q == PULSE_CNT_W'(1)) begin
`ifdef PULSE_PLAYBACK_LOOP_EN
            if (loop_rep_q) begin
              addr_d = loop_addr_q;
              rem_d  = loop_cnt_q;
            end else begin
              state_d = PB_DRAIN;
            end
`else
            state_d = PB_DRAIN;
`endif
          end
        end
      end
      PB_DRAIN: begin
        if (abort) begin
          state_d    = PB_IDLE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          fifo_flush = 1'b1;
          rdv_d      = 1'b0;
        end else if (acc && m_tlast) begin
          state_d = PB_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = PB_IDLE;
    endcase
  end

  pulse_skid_fifo u_fifo (
    .clk_i   (clka),
    .rst_i   (rsta),
    .flush_i (fifo_flush),
    .wr_en_i (rdv_q),
    .wr_i    ('{last: rdv_last_q, data: douta}),
    .rd_en_i (acc),
    .head_o  (head),
    .valid_o (m_tvalid),
    .count_o (fifo_count)
  );

  assign m_tdata = head.data;
  assign m_tlast = head.last & m_tvalid;
  assign ena     = ena_c;
  assign wea     = 1'b0;
  assign dina    = 32'd0;
  assign addra   = 32'(addr_q);
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_pulse_playback.sv
// Directed self-checking bench for pulse_playback with a 1-cycle-latency BRAM model (mem[i] = i+100).
module tb_pulse_playback;

  logic        clka = 1'b0;
  logic        rsta, start, abort, m_tready;
  logic [12:0] start_addr, num_samples;
  logic        busy, done, ena, wea, m_tvalid, m_tlast;
  logic [31:0] addra, dina, m_tdata;
  logic [31:0] douta = 32'd0;
`ifdef PULSE_PLAYBACK_LOOP_EN
  logic        repeat_i = 1'b0;
`endif

  logic [31:0] mem [0:7999];
  int n_checks = 0, n_fail = 0, cyc = 0;
  int ena_total, acc_total, max_out, stall_err, valid_cnt, busy_cnt;
  logic        prev_stall, prev_abort, prev_last;
  logic [31:0] prev_data;
  logic [31:0] ena_addr_q[$], acc_data_q[$];
  logic        acc_last_q[$];
  int          ena_cyc_q[$], acc_cyc_q[$], done_cyc_q[$];

  always #5 clka = ~clka;

  pulse_playback dut (
`ifdef PULSE_PLAYBACK_LOOP_EN
    .repeat_i    (repeat_i),
`endif
    .clka        (clka),
    .rsta        (rsta),
    .start       (start),
    .abort       (abort),
    .start_addr  (start_addr),
    .num_samples (num_samples),
    .busy        (busy),
    .done        (done),
    .ena         (ena),
    .wea         (wea),
    .addra       (addra),
    .dina        (dina),
    .douta       (douta),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast)
  );

  always @(posedge clka) begin
    if (ena) douta <= mem[addra[12:0]];
    cyc <= cyc + 1;
  end

  // Observation log, sampled mid-cycle.
  always @(negedge clka) begin
    if (!rsta) begin
      if (ena) begin ena_addr_q.push_back(addra); ena_cyc_q.push_back(cyc); ena_total++; end
      if (m_tvalid && m_tready) begin
        acc_data_q.push_back(m_tdata); acc_last_q.push_back(m_tlast);
        acc_cyc_q.push_back(cyc); acc_total++;
      end
      if (done) done_cyc_q.push_back(cyc);
      if (m_tvalid) valid_cnt++;
      if (busy) busy_cnt++;
      if (ena_total - acc_total > max_out) max_out = ena_total - acc_total;
      if (prev_stall && !prev_abort &&
          !(m_tvalid && m_tdata == prev_data && m_tlast == prev_last)) stall_err++;
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      prev_abort = abort;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clka); #1;
  endtask

  task automatic clear_logs();
    ena_addr_q.delete(); acc_data_q.delete(); acc_last_q.delete();
    ena_cyc_q.delete(); acc_cyc_q.delete(); done_cyc_q.delete();
    ena_total = 0; acc_total = 0; max_out = 0; stall_err = 0;
    valid_cnt = 0; busy_cnt = 0; prev_stall = 1'b0; prev_abort = 1'b0;
  endtask

  task automatic run_play(input int addr, input int n, output int k);
    start = 1'b1; start_addr = 13'(addr); num_samples = 13'(n); k = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (done_cyc_q.size() > 0) begin ok = 1'b1; break; end
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rsta = 1'b1; start = 1'b0; abort = 1'b0; m_tready = 1'b1;
    start_addr = '0; num_samples = '0;
    clear_logs();
    repeat (2) tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    n_checks++; if (ena !== 1'b0) begin n_fail++; $display("FAIL reset_ena got %b exp 0", ena); end
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %b exp 0", m_tvalid); end
    n_checks++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast got %b exp 0", m_tlast); end
    n_checks++; if (addra !== 32'd0) begin n_fail++; $display("FAIL reset_addra got %0d exp 0", addra); end
    n_checks++; if (m_tdata !== 32'd0) begin n_fail++; $display("FAIL reset_tdata got %0d exp 0", m_tdata); end
    n_checks++; if (wea !== 1'b0 || dina !== 32'd0) begin n_fail++; $display("FAIL reset_wr got wea=%b dina=%0d exp 0/0", wea, dina); end
    rsta = 1'b0;
    repeat (2) tick();
  endtask

  // Single-shot playback, compared address/data/last/timing against a hand-derived model.
  task automatic test_window(input string nm, input int addr, input int n);
    int k; bit ok; int e;
    clear_logs();
    run_play(addr, n, k);
    wait_done(60, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL %s_timeout got no done exp done", nm); end
    n_checks++; if (ena_addr_q.size() != n) begin n_fail++; $display("FAIL %s_nreads got %0d exp %0d", nm, ena_addr_q.size(), n); end
    n_checks++; if (acc_data_q.size() != n) begin n_fail++; $display("FAIL %s_nsamples got %0d exp %0d", nm, acc_data_q.size(), n); end
    for (int i = 0; i < n && i < ena_addr_q.size() && i < acc_data_q.size(); i++) begin
      e = (addr + i) % 8000;
      n_checks++; if (ena_addr_q[i] !== 32'(e) || ena_cyc_q[i] != k + 1 + i) begin
        n_fail++; $display("FAIL %s_addr[%0d] got %0d@%0d exp %0d@%0d", nm, i, ena_addr_q[i], ena_cyc_q[i], e, k + 1 + i); end
      n_checks++; if (acc_data_q[i] !== 32'(e + 100) || acc_cyc_q[i] != k + 3 + i) begin
        n_fail++; $display("FAIL %s_data[%0d] got %0d@%0d exp %0d@%0d", nm, i, acc_data_q[i], acc_cyc_q[i], e + 100, k + 3 + i); end
      n_checks++; if (acc_last_q[i] !== (i == n - 1)) begin
        n_fail++; $display("FAIL %s_last[%0d] got %b exp %b", nm, i, acc_last_q[i], i == n - 1); end
    end
    n_checks++; if (done_cyc_q.size() != 1 || (done_cyc_q.size() > 0 && done_cyc_q[0] != k + n + 3)) begin
      n_fail++; $display("FAIL %s_done got %0d pulses first@%0d exp 1@%0d", nm, done_cyc_q.size(),
                         done_cyc_q.size() > 0 ? done_cyc_q[0] : -1, k + n + 3); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_after got %b exp 0", nm, busy); end
  endtask

  task automatic test_empty();
    int k;
    clear_logs();
    run_play(50, 0, k);
    repeat (6) tick();
    n_checks++; if (done_cyc_q.size() != 1 || (done_cyc_q.size() > 0 && done_cyc_q[0] != k + 1)) begin
      n_fail++; $display("FAIL empty_done got %0d pulses exp 1@%0d", done_cyc_q.size(), k + 1); end
    n_checks++; if (ena_total != 0) begin n_fail++; $display("FAIL empty_ena got %0d exp 0", ena_total); end
    n_checks++; if (valid_cnt != 0) begin n_fail++; $display("FAIL empty_tvalid got %0d exp 0", valid_cnt); end
    n_checks++; if (busy_cnt != 0) begin n_fail++; $display("FAIL empty_busy got %0d exp 0", busy_cnt); end
  endtask

  task automatic test_backpressure();
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int k; bit ok;
    clear_logs();
    run_play(0, 8, k);
    ok = 1'b0;
    for (int j = 0; j < 200; j++) begin
      m_tready = pat[j % 4];
      tick();
      if (done_cyc_q.size() > 0) begin ok = 1'b1; break; end
    end
    m_tready = 1'b1;
    repeat (3) tick();
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_timeout got no done exp done"); end
    n_checks++; if (acc_data_q.size() != 8) begin n_fail++; $display("FAIL bp_nsamples got %0d exp 8", acc_data_q.size()); end
    for (int i = 0; i < 8 && i < acc_data_q.size(); i++) begin
      n_checks++; if (acc_data_q[i] !== 32'(100 + i) || acc_last_q[i] !== (i == 7)) begin
        n_fail++; $display("FAIL bp_data[%0d] got %0d last %b exp %0d last %b", i, acc_data_q[i], acc_last_q[i], 100 + i, i == 7); end
    end
    n_checks++; if (max_out > 2) begin n_fail++; $display("FAIL bp_outstanding got %0d exp <=2", max_out); end
    n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL bp_stable got %0d changes exp 0", stall_err); end
    n_checks++; if (ena_total != 8) begin n_fail++; $display("FAIL bp_nreads got %0d exp 8", ena_total); end
  endtask

  task automatic test_abort();
    int k, late;
    clear_logs();
    run_play(0, 16, k);
    while (cyc < k + 5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL abort_tvalid got %b exp 0", m_tvalid); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL abort_done got %b exp 1", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", busy); end
    repeat (6) tick();
    late = 0;
    foreach (ena_cyc_q[i]) if (ena_cyc_q[i] >= k + 5) late++;
    n_checks++; if (late != 0) begin n_fail++; $display("FAIL abort_late_ena got %0d exp 0", late); end
    n_checks++; if (acc_data_q.size() != 3 || (acc_data_q.size() == 3 && acc_data_q[2] !== 32'd102)) begin
      n_fail++; $display("FAIL abort_samples got %0d exp 3 ending 102", acc_data_q.size()); end
    n_checks++; if (done_cyc_q.size() != 1) begin n_fail++; $display("FAIL abort_done_count got %0d exp 1", done_cyc_q.size()); end
    test_window("after_abort", 20, 2);
  endtask

  task automatic test_reset_mid();
    int k;
    clear_logs();
    run_play(0, 16, k);
    repeat (3) tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_busy got %b exp 1", busy); end
    #2 rsta = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || ena !== 1'b0 || m_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async got busy=%b ena=%b tvalid=%b exp 0/0/0", busy, ena, m_tvalid); end
    tick();
    rsta = 1'b0;
    clear_logs();
    repeat (8) tick();
    n_checks++; if (done_cyc_q.size() != 0 || ena_total != 0) begin
      n_fail++; $display("FAIL midrst_after got done=%0d ena=%0d exp 0/0", done_cyc_q.size(), ena_total); end
  endtask

`ifdef PULSE_PLAYBACK_LOOP_EN
  task automatic test_loop();
    int k;
    clear_logs();
    repeat_i = 1'b1;
    run_play(0, 3, k);
    repeat_i = 1'b0;
    repeat (12) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) tick();
    n_checks++; if (acc_data_q.size() < 9) begin n_fail++; $display("FAIL loop_nsamples got %0d exp >=9", acc_data_q.size()); end
    for (int i = 0; i < 9 && i < acc_data_q.size(); i++) begin
      n_checks++; if (acc_data_q[i] !== 32'(100 + i % 3) || acc_last_q[i] !== (i % 3 == 2) || acc_cyc_q[i] != k + 3 + i) begin
        n_fail++; $display("FAIL loop_data[%0d] got %0d last %b @%0d exp %0d last %b @%0d", i, acc_data_q[i],
                           acc_last_q[i], acc_cyc_q[i], 100 + i % 3, i % 3 == 2, k + 3 + i); end
    end
    n_checks++; if (done_cyc_q.size() != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL loop_end got done=%0d busy=%b exp 1/0", done_cyc_q.size(), busy); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 8000; i++) mem[i] = 32'(i + 100);
    test_reset();
    test_window("basic", 10, 4);
    test_window("wrap", 7998, 4);
    test_empty();
    test_backpressure();
    test_abort();
    test_reset_mid();
`ifdef PULSE_PLAYBACK_LOOP_EN
    test_loop();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
